// File: rtl/servo_pkg.sv
// Shared constants and types for the servo angle ramp and its frame timer.
package servo_pkg;

    // Clock cycles per 20 ms PWM frame at 50 MHz; must match servo_pwm.
    localparam int FRAME_CYCLES_DEF = 1000000;
    // Largest legal angle in degrees; larger commands are clamped.
    localparam int MAX_ANGLE_DEF    = 180;
    // Angle driven after reset (servo centre).
    localparam int RESET_ANGLE_DEF  = 90;
    // Frame counter width; 2^20 covers one million cycles.
    localparam int CNT_W            = 20;

    // Ramp controller states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/servo_angle_ramp_if.sv
// Command and status bundle between the control logic and servo_angle_ramp.
//
// Handshake: a command transfers on every rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_angle/cmd_step are only
// meaningful while cmd_valid is high. cmd_ready is high at all times
// outside reset, so the master never stalls; the slave never drops a
// transferred command.
interface servo_angle_ramp_if;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [7:0]            cmd_angle;
    logic [3:0]            cmd_step;
    logic [7:0]            angle;
    logic                  frame_tick;
    logic                  busy;
    logic                  done;
    logic                  clamped;
    servo_pkg::state_t     state_dbg;

    // Command issuer / status consumer.
    modport master (
        output cmd_valid, cmd_angle, cmd_step,
        input  cmd_ready, angle, frame_tick, busy, done, clamped, state_dbg
    );

    // The ramp block itself.
    modport slave (
        input  cmd_valid, cmd_angle, cmd_step,
        output cmd_ready, angle, frame_tick, busy, done, clamped, state_dbg
    );
endinterface

// File: rtl/servo_frame_timer.sv
// Free-running 0..CYCLES-1 wrap counter with a registered tick that is high
// exactly during the cycle in which the counter holds CYCLES-1.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int CYCLES = FRAME_CYCLES_DEF,
    parameter int WIDTH  = CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;

    // Next counter value, wrapping after the last cycle of the frame.
    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + WIDTH'(1);
    end

    // Counter and tick register; tick is raised alongside cnt reaching LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == LAST);
        end
    end
endmodule

// File: rtl/servo_angle_ramp.sv
// Slews the servo angle toward a commanded target by a fixed step once per
// PWM frame, so the downstream PWM only sees angle changes on frame edges.
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int MAX_ANGLE    = MAX_ANGLE_DEF,
    parameter int RESET_ANGLE  = RESET_ANGLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    servo_angle_ramp_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RAMP = RAMP;
    localparam logic [7:0] MAX_A   = 8'(MAX_ANGLE);
    localparam logic [7:0] RST_A   = 8'(RESET_ANGLE);

    logic [0:0]        state;
    logic [7:0]        angle_q;
    logic [7:0]        target;
    logic [3:0]        step;
    logic              ready_q;
    logic              done_q;
    logic              tick;
    logic              accept;
    logic              over_max;
    logic [7:0]        cmd_target;
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic              finish;

    servo_frame_timer #(
        .CYCLES (FRAME_CYCLES),
        .WIDTH  (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Command decode and distance-to-target arithmetic in 9-bit signed form,
    // so neither the difference nor the final step can wrap.
    always_comb begin
        accept     = bus.cmd_valid && ready_q;
        over_max   = (bus.cmd_angle > MAX_A);
        cmd_target = over_max ? MAX_A : bus.cmd_angle;
        diff       = $signed({1'b0, target}) - $signed({1'b0, angle_q});
        mag        = diff[8] ? 9'(-diff) : 9'(diff);
        finish     = (step == 4'd0) || (mag <= {5'b0, step});
    end

    // Ramp FSM: tick updates use the registered target/step; a command
    // accepted in the same cycle is written afterwards and overrides state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            angle_q <= RST_A;
            target  <= RST_A;
            step    <= 4'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            if (tick && (state == ST_RAMP)) begin
                if (finish) begin
                    angle_q <= target;
                    done_q  <= 1'b1;
                    state   <= ST_IDLE;
                end else if (diff[8]) begin
                    angle_q <= angle_q - {4'b0, step};
                end else begin
                    angle_q <= angle_q + {4'b0, step};
                end
            end
            if (accept) begin
                target <= cmd_target;
                step   <= bus.cmd_step;
                state  <= ST_RAMP;
            end
        end
    end

    // Status outputs; clamped flags the accepting cycle itself.
    always_comb begin
        bus.cmd_ready  = ready_q;
        bus.angle      = angle_q;
        bus.frame_tick = tick;
        bus.busy       = (state == ST_RAMP);
        bus.done       = done_q;
        bus.clamped    = accept && over_max;
        bus.state_dbg  = state_t'(state);
    end
endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with a 100-cycle frame.
module tb_servo_angle_ramp;
    import servo_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    int   n_edges;

    servo_angle_ramp_if bus ();

    servo_angle_ramp #(
        .FRAME_CYCLES (100),
        .MAX_ANGLE    (180),
        .RESET_ANGLE  (90)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
    endtask

    // Advance until the current cycle is a frame_tick cycle; n = edges taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (!bus.frame_tick && n < 300);
        check("tick_seen", 32'(bus.frame_tick), 32'd1);
    endtask

    // Present a command for one cycle; clamped is checked before the edge.
    task automatic send_cmd(input logic [7:0] a, input logic [3:0] s, input logic exp_clamp);
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = a;
        bus.cmd_step  = s;
        #1;
        check("clamped", 32'(bus.clamped), 32'(exp_clamp));
        step_clk();
        bus.cmd_valid = 1'b0;
        check("busy_after_cmd", 32'(bus.busy), 32'd1);
    endtask

    // Wait for the next tick, then check the angle/done/busy it produced.
    task automatic tick_and_check(input string tag, input int exp_angle,
                                  input logic exp_done, input logic exp_busy);
        int n;
        wait_tick(n);
        step_clk();
        check({tag, "_angle"}, 32'(bus.angle), 32'(exp_angle));
        check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
        check({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        done_cnt      = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_angle = 8'd0;
        bus.cmd_step  = 4'd0;

        // 1. Reset values, ready after the first edge, tick cadence.
        #12;
        check("rst_angle", 32'(bus.angle), 32'd90);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_tick", 32'(bus.frame_tick), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_clk();
        check("ready_first_edge", 32'(bus.cmd_ready), 32'd1);
        check("idle_angle", 32'(bus.angle), 32'd90);
        wait_tick(n_edges);
        check("first_tick_cycle", 32'(n_edges + 1), 32'd99);
        wait_tick(n_edges);
        check("tick_period", 32'(n_edges), 32'd100);
        step_clk();

        // 2. 90 -> 100 in steps of 4, final step truncated.
        done_cnt = 0;
        send_cmd(8'd100, 4'd4, 1'b0);
        tick_and_check("t2_a", 94, 1'b0, 1'b1);
        tick_and_check("t2_b", 98, 1'b0, 1'b1);
        tick_and_check("t2_c", 100, 1'b1, 1'b0);
        step_clk();
        check("t2_done_once", 32'(done_cnt), 32'd1);

        // 3. Out-of-range command with step 0 clamps and jumps.
        send_cmd(8'd200, 4'd0, 1'b1);
        tick_and_check("t3", 180, 1'b1, 1'b0);

        // 4. Return to 90, then command issued in a tick cycle.
        send_cmd(8'd90, 4'd0, 1'b0);
        tick_and_check("t4_setup", 90, 1'b1, 1'b0);
        wait_tick(n_edges);
        send_cmd(8'd0, 4'd15, 1'b0);
        check("t4_same_tick_angle", 32'(bus.angle), 32'd90);
        tick_and_check("t4_75", 75, 1'b0, 1'b1);
        tick_and_check("t4_60", 60, 1'b0, 1'b1);
        tick_and_check("t4_45", 45, 1'b0, 1'b1);
        tick_and_check("t4_30", 30, 1'b0, 1'b1);
        tick_and_check("t4_15", 15, 1'b0, 1'b1);
        tick_and_check("t4_0", 0, 1'b1, 1'b0);

        // 5. Retarget mid-ramp; only the final target reports done.
        send_cmd(8'd90, 4'd0, 1'b0);
        tick_and_check("t5_setup", 90, 1'b1, 1'b0);
        step_clk();
        done_cnt = 0;
        send_cmd(8'd170, 4'd10, 1'b0);
        tick_and_check("t5_100", 100, 1'b0, 1'b1);
        tick_and_check("t5_110", 110, 1'b0, 1'b1);
        send_cmd(8'd60, 4'd10, 1'b0);
        tick_and_check("t5_r100", 100, 1'b0, 1'b1);
        tick_and_check("t5_r90", 90, 1'b0, 1'b1);
        tick_and_check("t5_r80", 80, 1'b0, 1'b1);
        tick_and_check("t5_r70", 70, 1'b0, 1'b1);
        tick_and_check("t5_r60", 60, 1'b1, 1'b0);
        step_clk();
        step_clk();
        check("t5_single_done", 32'(done_cnt), 32'd1);

        // 6. Asynchronous reset mid-ramp at 130.
        send_cmd(8'd170, 4'd10, 1'b0);
        tick_and_check("t6_70", 70, 1'b0, 1'b1);
        tick_and_check("t6_80", 80, 1'b0, 1'b1);
        tick_and_check("t6_90", 90, 1'b0, 1'b1);
        tick_and_check("t6_100", 100, 1'b0, 1'b1);
        tick_and_check("t6_110", 110, 1'b0, 1'b1);
        tick_and_check("t6_120", 120, 1'b0, 1'b1);
        tick_and_check("t6_130", 130, 1'b0, 1'b1);
        step_clk();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_angle", 32'(bus.angle), 32'd90);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        check("t6_async_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n_edges);
        check("t6_counter_restart", 32'(n_edges), 32'd99);
        step_clk();
        check("t6_discarded_angle", 32'(bus.angle), 32'd90);
        check("t6_discarded_busy", 32'(bus.busy), 32'd0);
        check("t6_discarded_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
